// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: STAGES slices, each built from GROUP-bit lookahead groups.
// Optional feature macro PIPELINED_CLA_SATURATE_EN adds a per-beat 'sat' input for signed saturation.
module pipelined_cla_adder #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
`ifdef PIPELINED_CLA_SATURATE_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int SW = WIDTH / STAGES;
    localparam int NG = SW / GROUP;

    // Sum-of-products lookahead carry into position n from (p,g) pairs 0..n-1 and carry-in c0.
    function automatic logic la_carry(input logic [SW-1:0] p, input logic [SW-1:0] g,
                                      input logic c0, input int n);
        logic c, t;
        c = c0;
        for (int m = 0; m < SW; m++) if (m < n) c = c & p[m];
        for (int i = 0; i < SW; i++) begin
            if (i < n) begin
                t = g[i];
                for (int m = 0; m < SW; m++) if (m > i && m < n) t = t & p[m];
                c = c | t;
            end
        end
        return c;
    endfunction

    // One slice: group P/G, group carries from the slice carry-in, then bit carries per group.
    function automatic logic [SW:0] cla_slice(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                              input logic c0);
        logic [SW-1:0] p, g, gp, gg, s;
        logic          gc;
        p  = x ^ y;
        g  = x & y;
        gp = {SW{1'b0}};
        gg = {SW{1'b0}};
        s  = {SW{1'b0}};
        for (int j = 0; j < NG; j++) begin
            gp[j] = &p[j*GROUP +: GROUP];
            gg[j] = la_carry(SW'(p[j*GROUP +: GROUP]), SW'(g[j*GROUP +: GROUP]), 1'b0, GROUP);
        end
        for (int j = 0; j < NG; j++) begin
            gc = la_carry(gp, gg, c0, j);
            for (int i = 0; i < GROUP; i++)
                s[j*GROUP+i] = p[j*GROUP+i] ^
                    la_carry(SW'(p[j*GROUP +: GROUP]), SW'(g[j*GROUP +: GROUP]), gc, i);
        end
        return {la_carry(gp, gg, c0, NG), s};
    endfunction

    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] r_c;
    logic [WIDTH-1:0]  r_a   [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];
    logic [WIDTH-1:0]  r_sum [STAGES];
    logic              r_ovf;
    logic              r_zero;
`ifdef PIPELINED_CLA_SATURATE_EN
    logic [STAGES-1:0] r_sat;
`endif

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stage
        logic             w_src_v;
        logic             w_src_c;
        logic [WIDTH-1:0] w_src_a;
        logic [WIDTH-1:0] w_src_b;
        logic [WIDTH-1:0] w_src_sum;
        logic [WIDTH-1:0] w_nsum;
        logic [WIDTH-1:0] w_ssum;
        logic [SW:0]      w_slice;
`ifdef PIPELINED_CLA_SATURATE_EN
        logic             w_src_sat;
`endif

        // Bubble-collapsing advance: a stage moves if any stage from here to the output is empty.
        assign w_adv[k] = out_ready | ~(&r_v[STAGES-1:k]);

        if (k == 0) begin : g_head
            assign w_src_v   = in_valid;
            assign w_src_a   = a;
            assign w_src_b   = b ^ {WIDTH{sub}};
            assign w_src_c   = cin ^ sub;
            assign w_src_sum = {WIDTH{1'b0}};
`ifdef PIPELINED_CLA_SATURATE_EN
            assign w_src_sat = sat;
`endif
        end else begin : g_body
            assign w_src_v   = r_v[k-1];
            assign w_src_a   = r_a[k-1];
            assign w_src_b   = r_b[k-1];
            assign w_src_c   = r_c[k-1];
            assign w_src_sum = r_sum[k-1];
`ifdef PIPELINED_CLA_SATURATE_EN
            assign w_src_sat = r_sat[k-1];
`endif
        end

        assign w_slice = cla_slice(w_src_a[k*SW +: SW], w_src_b[k*SW +: SW], w_src_c);

        // Merge this slice's bits into the partial sum carried from earlier slices.
        always_comb begin
            w_nsum             = w_src_sum;
            w_nsum[k*SW +: SW] = w_slice[SW-1:0];
        end

        if (k == STAGES - 1) begin : g_tail
            logic             w_ovf;
            logic [WIDTH-1:0] w_fin;

            // Signed overflow uses the post-inversion B operand.
            always_comb begin
                w_ovf = (w_src_a[WIDTH-1] == w_src_b[WIDTH-1]) &&
                        (w_nsum[WIDTH-1] != w_src_a[WIDTH-1]);
                w_fin = w_nsum;
`ifdef PIPELINED_CLA_SATURATE_EN
                if (w_src_sat && w_ovf) begin
                    w_fin = w_src_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
                end else begin
                    w_fin = w_nsum;
                end
`endif
            end
            assign w_ssum = w_fin;

            // Result flags register alongside the final sum.
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                end else if (w_adv[k] && w_src_v) begin
                    r_ovf  <= w_ovf;
                    r_zero <= ~|w_fin;
                end
            end
        end else begin : g_mid
            assign w_ssum = w_nsum;
        end

        // Stage register: takes the upstream beat when advancing, holds everything when stalled.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                r_v[k]   <= 1'b0;
                r_c[k]   <= 1'b0;
                r_a[k]   <= {WIDTH{1'b0}};
                r_b[k]   <= {WIDTH{1'b0}};
                r_sum[k] <= {WIDTH{1'b0}};
`ifdef PIPELINED_CLA_SATURATE_EN
                r_sat[k] <= 1'b0;
`endif
            end else if (w_adv[k]) begin
                r_v[k] <= w_src_v;
                if (w_src_v) begin
                    r_c[k]   <= w_slice[SW];
                    r_a[k]   <= w_src_a;
                    r_b[k]   <= w_src_b;
                    r_sum[k] <= w_ssum;
`ifdef PIPELINED_CLA_SATURATE_EN
                    r_sat[k] <= w_src_sat;
`endif
                end
            end
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = r_v[STAGES-1];
    assign sum       = r_sum[STAGES-1];
    assign cout      = r_c[STAGES-1];
    assign ovf       = r_ovf;
    assign zero      = r_zero;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed + scoreboard bench for pipelined_cla_adder (32-bit, GROUP 4, STAGES 2).
module tb_pipelined_cla_adder;
    localparam int STG = 2;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic        Clk, Reset, in_valid, in_ready, sub, cin, sat;
    logic        out_valid, out_ready, cout, ovf, zero;
    logic [31:0] a, b, sum;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    logic        mon_en = 1'b0;
    logic        bp_en  = 1'b0;
    logic [15:0] bp_pat = 16'hD369;
    int          bp_i   = 0;
    logic        hold_v = 1'b0;
    logic [31:0] hold_sum;
    logic [2:0]  hold_f;

    pipelined_cla_adder #(.WIDTH(32), .GROUP(4), .STAGES(STG)) dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin),
`ifdef PIPELINED_CLA_SATURATE_EN
        .sat(sat),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic s, input logic c, input logic st);
        exp_t        e;
        logic [31:0] yy;
        logic [32:0] r;
        yy     = s ? ~y : y;
        r      = {1'b0, x} + {1'b0, yy} + {32'd0, (s ? ~c : c)};
        e.sum  = r[31:0];
        e.cout = r[32];
        e.ovf  = (x[31] == yy[31]) && (r[31] != x[31]);
`ifdef PIPELINED_CLA_SATURATE_EN
        if (st && e.ovf) e.sum = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
        if (st) e.sum = r[31:0];
`endif
        e.zero = (e.sum == 32'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y,
                        input logic s, input logic c, input logic st);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        a = x; b = y; sub = s; cin = c; sat = st;
        in_valid = 1'b1;
        while (!acc && n < 100) begin
            @(negedge Clk);
            acc = in_ready;
            @(posedge Clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (acc) q.push_back(model(x, y, s, c, st));
        chk("accept", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge Clk);
            #1;
            n++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic check_latency();
        for (int i = 1; i < STG; i++) begin
            chk("lat_early", 32'(out_valid), 32'd0);
            @(posedge Clk);
            #1;
        end
        chk("lat_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_sum"}, sum, 32'd0);
        chk({tag, "_cout"}, 32'(cout), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf), 32'd0);
        chk({tag, "_zero"}, 32'(zero), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Backpressure pattern generator
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (bp_en) begin
                out_ready = bp_pat[bp_i];
                bp_i = (bp_i + 1) % 16;
            end
        end
    end

    // Output monitor: in_ready rule, stall stability, scoreboard compare
    always @(negedge Clk) begin
        exp_t e;
        if (!mon_en) begin
            hold_v = 1'b0;
        end else begin
            chk("in_ready", 32'(in_ready), 32'(out_ready || (q.size() < STG)));
            if (hold_v) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_sum", sum, hold_sum);
                chk("hold_flags", 32'({cout, ovf, zero}), 32'(hold_f));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    chk("sum", sum, e.sum);
                    chk("cout", 32'(cout), 32'(e.cout));
                    chk("ovf", 32'(ovf), 32'(e.ovf));
                    chk("zero", 32'(zero), 32'(e.zero));
                end
            end
            hold_v   = out_valid && !out_ready;
            hold_sum = sum;
            hold_f   = {cout, ovf, zero};
        end
    end

    initial begin
        Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 32'd0; b = 32'd0; sub = 1'b0; cin = 1'b0; sat = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        check_idle("reset");
        @(posedge Clk);
        #1;
        mon_en = 1'b1;
        out_ready = 1'b1;

        // Carry across the slice boundary at bit 16, with latency check
        send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        check_latency();
        drain();

        // Wrap-around and subtract cases back to back
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        send(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0007, 32'h0000_0007, 1'b1, 1'b0, 1'b0);
        drain();

        // Back-to-back stream under toggling backpressure
        bp_en = 1'b1;
        for (int i = 0; i < 24; i++)
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        bp_en = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        send(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b1, 1'b0);
        mon_en = 1'b0;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        q.delete();
        check_idle("midreset");
        mon_en = 1'b1;
        out_ready = 1'b1;
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0);
        check_latency();
        drain();

`ifdef PIPELINED_CLA_SATURATE_EN
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
        drain();
`endif

        repeat (2) @(posedge Clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
